// File: rtl/vga_circle_layers_pkg.sv
// Shared types and constants for the layered-circle VGA renderer.
// Key codes match the Keypad scan codes; widths match the vgac scan counters.
package vga_layers_pkg;
    localparam int COLOR_W = 12;
    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int R_W     = 10;

    localparam logic [4:0] KEY_LEFT   = 5'h0c;
    localparam logic [4:0] KEY_RIGHT  = 5'h0e;
    localparam logic [4:0] KEY_UP     = 5'h09;
    localparam logic [4:0] KEY_DOWN   = 5'h11;
    localparam logic [4:0] KEY_SHRINK = 5'h10;
    localparam logic [4:0] KEY_GROW   = 5'h12;
    localparam logic [4:0] KEY_NEXT   = 5'h0d;
    localparam logic [4:0] KEY_HIDE   = 5'h05;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        APPLY    = 2'd1,
        WAIT_REL = 2'd2
    } key_state_t;

    function automatic logic [9:0] clamp_s11(input logic signed [10:0] v,
                                             input logic signed [10:0] lo,
                                             input logic signed [10:0] hi);
        logic [9:0] res;
        if (v < lo)      res = lo[9:0];
        else if (v > hi) res = hi[9:0];
        else             res = v[9:0];
        return res;
    endfunction
endpackage

// File: rtl/vga_circle_layers_circle_hit_test.sv
// Per-circle pixel test: stage 1 registers |dx|,|dy| plus a geometry snapshot;
// the hit bit is derived from those registers and captured by the top's stage-2 register.
module circle_hit_test
    import vga_layers_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           pix_en,
    input  logic [X_W-1:0] col_addr,
    input  logic [Y_W-1:0] row_addr,
    input  logic [X_W-1:0] cx,
    input  logic [Y_W-1:0] cy,
    input  logic [R_W-1:0] cr,
    input  logic           cvis,
    output logic           hit
);
    logic [X_W-1:0] dx_q;
    logic [Y_W-1:0] dy_q;
    logic [R_W-1:0] r_q;
    logic           vis_q;
    logic [19:0]    dx2;
    logic [17:0]    dy2;
    logic [19:0]    r2;
    logic [20:0]    dist2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dx_q  <= '0;
            dy_q  <= '0;
            r_q   <= '0;
            vis_q <= 1'b0;
        end else if (pix_en) begin
            dx_q  <= (cx >= col_addr) ? cx - col_addr : col_addr - cx;
            dy_q  <= (cy >= row_addr) ? cy - row_addr : row_addr - cy;
            r_q   <= cr;
            vis_q <= cvis;
        end
    end

    always_comb begin
        dx2   = dx_q * dx_q;
        dy2   = dy_q * dy_q;
        r2    = r_q * r_q;
        dist2 = 21'(dx2) + 21'(dy2);
        hit   = vis_q & (dist2 < 21'(r2));
    end
endmodule

// File: rtl/vga_circle_layers.sv
// Keypad-driven editor for N_CIRC layered filled circles, rendered through a
// two-stage pixel pipeline; index 0 is the top-most layer.
module vga_circle_layers
    import vga_layers_pkg::*;
#(
    parameter int               N_CIRC   = 4,
    parameter int               H_RES    = 640,
    parameter int               V_RES    = 480,
    parameter int               STEP_XY  = 20,
    parameter int               STEP_R   = 5,
    parameter int               R_MIN    = 5,
    parameter int               R_MAX    = 200,
    parameter int               R_INIT   = 15,
    parameter logic [COLOR_W-1:0] BG_COLOR = 12'hfff
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pix_en,
    input  logic [X_W-1:0]              col_addr,
    input  logic [Y_W-1:0]              row_addr,
    input  logic [4:0]                  key_code,
    input  logic                        key_ready,
    input  logic [COLOR_W*N_CIRC-1:0]   color_in,
    output logic [COLOR_W-1:0]          pix_data,
    output logic [2:0]                  sel_idx,
    output logic [X_W-1:0]              sel_x,
    output logic [Y_W-1:0]              sel_y,
    output logic [R_W-1:0]              sel_r,
    output logic                        sel_vis
);
    localparam logic signed [10:0] S_XY  = 11'(STEP_XY);
    localparam logic signed [10:0] S_R   = 11'(STEP_R);
    localparam logic signed [10:0] ZERO  = 11'sd0;
    localparam logic signed [10:0] X_MAX = 11'(H_RES - 1);
    localparam logic signed [10:0] Y_MAX = 11'(V_RES - 1);
    localparam logic signed [10:0] R_LO  = 11'(R_MIN);
    localparam logic signed [10:0] R_HI  = 11'(R_MAX);

    key_state_t     state, state_nxt;
    logic           key_rdy_q, key_armed, key_rise, apply;
    logic [4:0]     code_q;
    logic [2:0]     sel_q;
    logic [X_W-1:0] x_q [N_CIRC];
    logic [Y_W-1:0] y_q [N_CIRC];
    logic [R_W-1:0] r_q [N_CIRC];
    logic           vis_q [N_CIRC];
    logic signed [10:0] sx_s, sy_s, sr_s;
    logic [X_W-1:0] x_dec, x_inc;
    logic [Y_W-1:0] y_dec, y_inc;
    logic [R_W-1:0] r_dec, r_inc;
    logic [N_CIRC-1:0]  hit;
    logic [COLOR_W-1:0] pix_nxt;

    // A key still held through reset must be released before it can act again.
    assign key_rise = key_ready & ~key_rdy_q & key_armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            key_rdy_q <= 1'b0;
            key_armed <= 1'b0;
            code_q    <= '0;
        end else begin
            state     <= state_nxt;
            key_rdy_q <= key_ready;
            key_armed <= key_armed | ~key_ready;
            if (key_rise) code_q <= key_code;
        end
    end

    always_comb begin
        state_nxt = state;
        apply     = 1'b0;
        case (state)
            IDLE:     if (key_rise) state_nxt = APPLY;
            APPLY: begin
                apply     = 1'b1;
                state_nxt = WAIT_REL;
            end
            WAIT_REL: if (!key_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sel_x   = '0;
        sel_y   = '0;
        sel_r   = '0;
        sel_vis = 1'b0;
        for (int i = 0; i < N_CIRC; i++) begin
            if (sel_q == 3'(i)) begin
                sel_x   = x_q[i];
                sel_y   = y_q[i];
                sel_r   = r_q[i];
                sel_vis = vis_q[i];
            end
        end
        sx_s  = {1'b0, sel_x};
        sy_s  = {2'b00, sel_y};
        sr_s  = {1'b0, sel_r};
        x_dec = clamp_s11(sx_s - S_XY, ZERO, X_MAX);
        x_inc = clamp_s11(sx_s + S_XY, ZERO, X_MAX);
        y_dec = Y_W'(clamp_s11(sy_s - S_XY, ZERO, Y_MAX));
        y_inc = Y_W'(clamp_s11(sy_s + S_XY, ZERO, Y_MAX));
        r_dec = clamp_s11(sr_s - S_R, R_LO, R_HI);
        r_inc = clamp_s11(sr_s + S_R, R_LO, R_HI);
    end

    assign sel_idx = sel_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= '0;
            for (int i = 0; i < N_CIRC; i++) begin
                x_q[i]   <= X_W'((i + 1) * H_RES / (N_CIRC + 1));
                y_q[i]   <= Y_W'(V_RES / 2);
                r_q[i]   <= R_W'(R_INIT);
                vis_q[i] <= 1'b1;
            end
        end else if (apply) begin
            if (code_q == KEY_NEXT)
                sel_q <= (sel_q == 3'(N_CIRC - 1)) ? 3'd0 : sel_q + 3'd1;
            for (int i = 0; i < N_CIRC; i++) begin
                if (sel_q == 3'(i)) begin
                    case (code_q)
                        KEY_LEFT:   x_q[i]   <= x_dec;
                        KEY_RIGHT:  x_q[i]   <= x_inc;
                        KEY_UP:     y_q[i]   <= y_dec;
                        KEY_DOWN:   y_q[i]   <= y_inc;
                        KEY_SHRINK: r_q[i]   <= r_dec;
                        KEY_GROW:   r_q[i]   <= r_inc;
                        KEY_HIDE:   vis_q[i] <= ~vis_q[i];
                        default: ;
                    endcase
                end
            end
        end
    end

    for (genvar g = 0; g < N_CIRC; g++) begin : g_circ
        circle_hit_test u_hit (
            .clk      (clk),
            .rst      (rst),
            .pix_en   (pix_en),
            .col_addr (col_addr),
            .row_addr (row_addr),
            .cx       (x_q[g]),
            .cy       (y_q[g]),
            .cr       (r_q[g]),
            .cvis     (vis_q[g]),
            .hit      (hit[g])
        );
    end

    // Scan from the bottom layer up so the lowest visible index wins.
    always_comb begin
        pix_nxt = BG_COLOR;
        for (int i = N_CIRC - 1; i >= 0; i--)
            if (hit[i]) pix_nxt = color_in[COLOR_W*i +: COLOR_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         pix_data <= BG_COLOR;
        else if (pix_en) pix_data <= pix_nxt;
    end
endmodule

// File: tb/tb_vga_circle_layers.sv
// Self-checking bench for vga_circle_layers: a behavioural geometry model feeds a
// scoreboard queue of expected selected-circle values and pixel colours.
module tb_vga_circle_layers;
    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic [9:0]  col_addr;
    logic [8:0]  row_addr;
    logic [4:0]  key_code;
    logic        key_ready;
    logic [47:0] color_in;
    logic [11:0] pix_data;
    logic [2:0]  sel_idx;
    logic [9:0]  sel_x;
    logic [8:0]  sel_y;
    logic [9:0]  sel_r;
    logic        sel_vis;

    int n_checks = 0;
    int n_fail   = 0;

    int mx [4];
    int my [4];
    int mr [4];
    bit mv [4];
    int msel;
    logic [11:0] colors [4];
    int sb_q [$];

    vga_circle_layers dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .col_addr(col_addr), .row_addr(row_addr),
        .key_code(key_code), .key_ready(key_ready), .color_in(color_in),
        .pix_data(pix_data), .sel_idx(sel_idx), .sel_x(sel_x), .sel_y(sel_y),
        .sel_r(sel_r), .sel_vis(sel_vis)
    );

    always #5 clk = ~clk;

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mx[i] = (i + 1) * 640 / 5;
            my[i] = 240;
            mr[i] = 15;
            mv[i] = 1'b1;
        end
        msel = 0;
    endtask

    task automatic model_apply(input logic [4:0] c);
        case (c)
            5'h0c: mx[msel] = clampi(mx[msel] - 20, 0, 639);
            5'h0e: mx[msel] = clampi(mx[msel] + 20, 0, 639);
            5'h09: my[msel] = clampi(my[msel] - 20, 0, 479);
            5'h11: my[msel] = clampi(my[msel] + 20, 0, 479);
            5'h10: mr[msel] = clampi(mr[msel] - 5, 5, 200);
            5'h12: mr[msel] = clampi(mr[msel] + 5, 5, 200);
            5'h0d: msel = (msel + 1) % 4;
            5'h05: mv[msel] = !mv[msel];
            default: ;
        endcase
    endtask

    function automatic int exp_pixel(input int c, input int r);
        int dx, dy;
        for (int i = 0; i < 4; i++) begin
            dx = mx[i] - c;
            dy = my[i] - r;
            if (mv[i] && (dx * dx + dy * dy < mr[i] * mr[i])) return int'(colors[i]);
        end
        return 32'hfff;
    endfunction

    task automatic press(input logic [4:0] c, input int hold);
        @(negedge clk);
        key_code  = c;
        key_ready = 1'b1;
        repeat (hold) @(negedge clk);
        key_ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic probe(input int c, input int r);
        @(negedge clk);
        col_addr = 10'(c);
        row_addr = 9'(r);
        pix_en   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pix_en = 1'b0;
    endtask

    task automatic test_reset();
        int e;
        rst = 1'b1; pix_en = 1'b0; key_ready = 1'b0; key_code = '0;
        col_addr = '0; row_addr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++; if (pix_data !== 12'hfff) begin n_fail++; $display("FAIL reset_pix: got %h expected fff", pix_data); end
        n_checks++; if (sel_idx !== 3'd0) begin n_fail++; $display("FAIL reset_sel_idx: got %0d expected 0", sel_idx); end
        n_checks++; if (sel_x !== 10'd128) begin n_fail++; $display("FAIL reset_sel_x: got %0d expected 128", sel_x); end
        n_checks++; if (sel_y !== 9'd240) begin n_fail++; $display("FAIL reset_sel_y: got %0d expected 240", sel_y); end
        n_checks++; if (sel_r !== 10'd15) begin n_fail++; $display("FAIL reset_sel_r: got %0d expected 15", sel_r); end
        n_checks++; if (sel_vis !== 1'b1) begin n_fail++; $display("FAIL reset_sel_vis: got %0d expected 1", sel_vis); end
        // One strobe must not yet reach pix_data; the second one must.
        col_addr = 10'd128; row_addr = 9'd240; pix_en = 1'b1;
        @(negedge clk); pix_en = 1'b0;
        n_checks++; if (pix_data !== 12'hfff) begin n_fail++; $display("FAIL latency_1strobe: got %h expected fff", pix_data); end
        repeat (2) @(negedge clk);
        pix_en = 1'b1;
        @(negedge clk); pix_en = 1'b0;
        n_checks++; if (pix_data !== 12'h0a1) begin n_fail++; $display("FAIL latency_2strobe: got %h expected 0a1", pix_data); end
        col_addr = '0; row_addr = '0;
        repeat (5) @(negedge clk);
        n_checks++; if (pix_data !== 12'h0a1) begin n_fail++; $display("FAIL pix_en_hold: got %h expected 0a1", pix_data); end
        sb_q.push_back(exp_pixel(0, 0));
        probe(0, 0);
        e = sb_q.pop_front();
        n_checks++; if (int'(pix_data) !== e) begin n_fail++; $display("FAIL bg_pixel: got %h expected %h", pix_data, e); end
    endtask

    task automatic move_seq(input logic [4:0] c, input int n);
        int e;
        for (int k = 0; k < n; k++) begin
            model_apply(c);
            sb_q.push_back(mx[msel]);
            sb_q.push_back(my[msel]);
            press(c, 2);
            e = sb_q.pop_front();
            n_checks++; if (int'(sel_x) !== e) begin n_fail++; $display("FAIL move_x code %h step %0d: got %0d expected %0d", c, k, sel_x, e); end
            e = sb_q.pop_front();
            n_checks++; if (int'(sel_y) !== e) begin n_fail++; $display("FAIL move_y code %h step %0d: got %0d expected %0d", c, k, sel_y, e); end
        end
    endtask

    task automatic test_move_clamp();
        move_seq(5'h0c, 7);
        n_checks++; if (sel_x !== 10'd0) begin n_fail++; $display("FAIL clamp_x_low: got %0d expected 0", sel_x); end
        move_seq(5'h0e, 33);
        n_checks++; if (sel_x !== 10'd639) begin n_fail++; $display("FAIL clamp_x_high: got %0d expected 639", sel_x); end
        move_seq(5'h0c, 32);
        move_seq(5'h11, 13);
        n_checks++; if (sel_y !== 9'd479) begin n_fail++; $display("FAIL clamp_y_high: got %0d expected 479", sel_y); end
        move_seq(5'h09, 25);
        n_checks++; if (sel_y !== 9'd0) begin n_fail++; $display("FAIL clamp_y_low: got %0d expected 0", sel_y); end
        move_seq(5'h11, 12);
    endtask

    task automatic test_radius();
        int e;
        for (int k = 0; k < 100; k++) begin
            logic [4:0] c;
            c = (k < 40) ? 5'h12 : 5'h10;
            model_apply(c);
            sb_q.push_back(mr[msel]);
            press(c, 2);
            e = sb_q.pop_front();
            n_checks++; if (int'(sel_r) !== e) begin n_fail++; $display("FAIL radius step %0d: got %0d expected %0d", k, sel_r, e); end
            if (k == 39) begin
                n_checks++; if (sel_r !== 10'd200) begin n_fail++; $display("FAIL r_max: got %0d expected 200", sel_r); end
            end
        end
        n_checks++; if (sel_r !== 10'd5) begin n_fail++; $display("FAIL r_min: got %0d expected 5", sel_r); end
        // Circle 0 sits at (0,240) with r=5: distance exactly r is outside.
        probe(5, 240);
        n_checks++; if (pix_data !== 12'hfff) begin n_fail++; $display("FAIL edge_dist_r: got %h expected fff", pix_data); end
        probe(3, 244);
        n_checks++; if (pix_data !== 12'hfff) begin n_fail++; $display("FAIL edge_3_4_5: got %h expected fff", pix_data); end
        probe(4, 240);
        n_checks++; if (pix_data !== 12'h0a1) begin n_fail++; $display("FAIL inside_r: got %h expected 0a1", pix_data); end
    endtask

    task automatic test_select();
        int e;
        for (int k = 0; k < 4; k++) begin
            model_apply(5'h0d);
            sb_q.push_back(msel);
            press(5'h0d, 2);
            e = sb_q.pop_front();
            n_checks++; if (int'(sel_idx) !== e) begin n_fail++; $display("FAIL select step %0d: got %0d expected %0d", k, sel_idx, e); end
        end
        model_apply(5'h0d);
        press(5'h0d, 100);
        n_checks++; if (sel_idx !== 3'd1) begin n_fail++; $display("FAIL held_key_single: got %0d expected 1", sel_idx); end
    endtask

    task automatic test_overlap();
        move_seq(5'h0c, 13);
        probe(2, 240);
        n_checks++; if (pix_data !== 12'h0a1) begin n_fail++; $display("FAIL overlap_top: got %h expected 0a1", pix_data); end
        probe(10, 240);
        n_checks++; if (pix_data !== 12'h0b2) begin n_fail++; $display("FAIL overlap_outer: got %h expected 0b2", pix_data); end
        for (int k = 0; k < 3; k++) begin model_apply(5'h0d); press(5'h0d, 2); end
        model_apply(5'h05);
        press(5'h05, 2);
        n_checks++; if (sel_vis !== 1'b0) begin n_fail++; $display("FAIL hide_vis: got %0d expected 0", sel_vis); end
        probe(2, 240);
        n_checks++; if (pix_data !== 12'h0b2) begin n_fail++; $display("FAIL hidden_top: got %h expected 0b2", pix_data); end
        model_apply(5'h05);
        press(5'h05, 2);
        probe(2, 240);
        n_checks++; if (pix_data !== 12'h0a1) begin n_fail++; $display("FAIL unhide_top: got %h expected 0a1", pix_data); end
    endtask

    task automatic test_random();
        logic [4:0] codes [9];
        logic [4:0] c;
        int e, pc, pr;
        codes = '{5'h0c, 5'h0e, 5'h09, 5'h11, 5'h10, 5'h12, 5'h0d, 5'h05, 5'h1f};
        for (int k = 0; k < 40; k++) begin
            c = codes[$urandom_range(0, 8)];
            model_apply(c);
            sb_q.push_back(msel);
            sb_q.push_back(mx[msel]);
            sb_q.push_back(my[msel]);
            sb_q.push_back(mr[msel]);
            sb_q.push_back(int'(mv[msel]));
            press(c, $urandom_range(1, 4));
            e = sb_q.pop_front(); n_checks++; if (int'(sel_idx) !== e) begin n_fail++; $display("FAIL rand_idx %0d: got %0d expected %0d", k, sel_idx, e); end
            e = sb_q.pop_front(); n_checks++; if (int'(sel_x) !== e) begin n_fail++; $display("FAIL rand_x %0d: got %0d expected %0d", k, sel_x, e); end
            e = sb_q.pop_front(); n_checks++; if (int'(sel_y) !== e) begin n_fail++; $display("FAIL rand_y %0d: got %0d expected %0d", k, sel_y, e); end
            e = sb_q.pop_front(); n_checks++; if (int'(sel_r) !== e) begin n_fail++; $display("FAIL rand_r %0d: got %0d expected %0d", k, sel_r, e); end
            e = sb_q.pop_front(); n_checks++; if (int'(sel_vis) !== e) begin n_fail++; $display("FAIL rand_vis %0d: got %0d expected %0d", k, sel_vis, e); end
        end
        for (int k = 0; k < 12; k++) begin
            pr = $urandom_range(0, 3);
            pc = mx[pr] + int'($urandom_range(0, 30)) - 15;
            pr = my[pr] + int'($urandom_range(0, 30)) - 15;
            pc = clampi(pc, 0, 639);
            pr = clampi(pr, 0, 479);
            sb_q.push_back(exp_pixel(pc, pr));
            probe(pc, pr);
            e = sb_q.pop_front();
            n_checks++; if (int'(pix_data) !== e) begin n_fail++; $display("FAIL rand_pix (%0d,%0d): got %h expected %h", pc, pr, pix_data, e); end
        end
    endtask

    task automatic test_reset_apply();
        @(negedge clk);
        key_code  = 5'h0e;
        key_ready = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        n_checks++; if (sel_x !== 10'd128) begin n_fail++; $display("FAIL rst_apply_x: got %0d expected 128", sel_x); end
        n_checks++; if (sel_idx !== 3'd0) begin n_fail++; $display("FAIL rst_apply_idx: got %0d expected 0", sel_idx); end
        n_checks++; if (sel_r !== 10'd15) begin n_fail++; $display("FAIL rst_apply_r: got %0d expected 15", sel_r); end
        n_checks++; if (pix_data !== 12'hfff) begin n_fail++; $display("FAIL rst_apply_pix: got %h expected fff", pix_data); end
        key_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (sel_x !== 10'd128) begin n_fail++; $display("FAIL rst_release_x: got %0d expected 128", sel_x); end
        model_apply(5'h0e);
        press(5'h0e, 2);
        n_checks++; if (sel_x !== 10'd148) begin n_fail++; $display("FAIL repress_x: got %0d expected 148", sel_x); end
    endtask

    initial begin
        colors   = '{12'h0a1, 12'h0b2, 12'h0c3, 12'h0d4};
        color_in = {12'h0d4, 12'h0c3, 12'h0b2, 12'h0a1};
        test_reset();
        test_move_clamp();
        test_radius();
        test_select();
        test_overlap();
        test_random();
        test_reset_apply();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
